// File: rtl/vga_pattern_gen_pkg.sv
// Shared definitions for vga_pattern_gen: mode encodings, RGB565 colours and 1024x768@60 timing.
// VGA_PATTERN_EXT_EN adds the external-pixel mode and moves the mode wrap point to 10.
package vga_pattern_pkg;

  typedef enum logic [3:0] {
    MODE_WHITE  = 4'd0,
    MODE_RED    = 4'd1,
    MODE_GREEN  = 4'd2,
    MODE_BLUE   = 4'd3,
    MODE_GRID16 = 4'd4,
    MODE_GRID64 = 4'd5,
    MODE_HGRAD  = 4'd6,
    MODE_VGRAD  = 4'd7,
    MODE_BARS   = 4'd8,
    MODE_BORDER = 4'd9,
    MODE_EXT    = 4'd10
  } mode_e;

`ifdef VGA_PATTERN_EXT_EN
  localparam logic [3:0] MODE_LAST = MODE_EXT;
`else
  localparam logic [3:0] MODE_LAST = MODE_BORDER;
`endif

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_BP     = 160;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 29;

  // Index 8 and above is the remainder region to the right of the last bar.
  function automatic logic [15:0] bar_color(input logic [3:0] idx);
    case (idx)
      4'd0:    return RGB_WHITE;
      4'd1:    return RGB_YELLOW;
      4'd2:    return RGB_CYAN;
      4'd3:    return RGB_GREEN;
      4'd4:    return RGB_MAGENTA;
      4'd5:    return RGB_RED;
      4'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// VGA output bundle driven by vga_pattern_gen: syncs, enable, RGB565, frame marker and mode.
interface vga_pattern_gen_if;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_de;
  logic [4:0] vga_r;
  logic [5:0] vga_g;
  logic [4:0] vga_b;
  logic       frame_start;
  logic [3:0] mode;

  modport master (output vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_start, mode);
  modport slave  (input  vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_start, mode);
endinterface

// File: rtl/vga_pattern_gen_key_debounce.sv
// Key debouncer: 2-FF synchroniser, saturating high-time counter, one pulse per accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CYCLES - 2);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  // press_q rises on the same edge that moves the counter to DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      if (!sync2_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      press_q <= sync2_q && (cnt_q == CNT_FIRE);
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and ten-pattern test generator; key-selected mode applied at frame start.
// Optional VGA_PATTERN_EXT_EN adds ext_rgb/ext_req and a pass-through mode 10.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter bit HS_POL          = 1'b0,
  parameter bit VS_POL          = 1'b0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              vga_clk,
  input  logic              vga_rst_n,
  input  logic              key3,
  vga_pattern_gen_if.master vga
`ifdef VGA_PATTERN_EXT_EN
  ,
  input  logic [15:0]       ext_rgb,
  output logic              ext_req
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int BW      = $clog2(BAR_W + 1);

  logic          run_q;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [BW-1:0] bar_w_q, bar_w_d;
  logic [3:0]    bar_idx_q, bar_idx_d;

  logic          hs_q, vs_q, de_q, fs_q;
  logic [15:0]   rgb_q;
  logic [3:0]    mode_q, pending_q;
  logic          press;

  // Bar index tracks the counter's x via a width counter restarted at the first active column.
  always_comb begin
    h_cnt_d   = h_cnt_q + 1'b1;
    v_cnt_d   = v_cnt_q;
    if (h_cnt_q == HW'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
    end
    bar_w_d   = bar_w_q + 1'b1;
    bar_idx_d = bar_idx_q;
    if (h_cnt_d == HW'(H_START)) begin
      bar_w_d   = '0;
      bar_idx_d = '0;
    end else if (bar_w_q == BW'(BAR_W - 1)) begin
      bar_w_d = '0;
      if (bar_idx_q != 4'd8) bar_idx_d = bar_idx_q + 1'b1;
    end
  end

  // run_q holds the counters at (0,0) for the first edge after reset release.
  always_ff @(posedge vga_clk) begin
    if (!vga_rst_n) begin
      run_q     <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_w_q   <= '0;
      bar_idx_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        h_cnt_q   <= h_cnt_d;
        v_cnt_q   <= v_cnt_d;
        bar_w_q   <= bar_w_d;
        bar_idx_q <= bar_idx_d;
      end
    end
  end

  logic [15:0] hpos, vpos, x, y;
  logic        active, origin;
  logic [15:0] pix_d;

  assign hpos   = 16'(h_cnt_q);
  assign vpos   = 16'(v_cnt_q);
  assign x      = hpos - 16'(H_START);
  assign y      = vpos - 16'(V_START);
  assign active = (hpos >= 16'(H_START)) && (hpos < 16'(H_START + H_ACTIVE)) &&
                  (vpos >= 16'(V_START)) && (vpos < 16'(V_START + V_ACTIVE));
  assign origin = (h_cnt_q == '0) && (v_cnt_q == '0);

  always_comb begin
    pix_d = RGB_BLACK;
    if (active) begin
      case (mode_q)
        MODE_WHITE:  pix_d = RGB_WHITE;
        MODE_RED:    pix_d = RGB_RED;
        MODE_GREEN:  pix_d = RGB_GREEN;
        MODE_BLUE:   pix_d = RGB_BLUE;
        MODE_GRID16: pix_d = (x[4] ^ y[4]) ? RGB_BLACK : RGB_WHITE;
        MODE_GRID64: pix_d = (x[6] ^ y[6]) ? RGB_BLACK : RGB_WHITE;
        MODE_HGRAD:  pix_d = {x[6:2], x[6:1], x[6:2]};
        MODE_VGRAD:  pix_d = {y[6:2], y[6:1], y[6:2]};
        MODE_BARS:   pix_d = bar_color(bar_idx_q);
        MODE_BORDER: pix_d = (x == 16'd0 || x == 16'(H_ACTIVE - 1) ||
                              y == 16'd0 || y == 16'(V_ACTIVE - 1)) ? RGB_WHITE : RGB_BLACK;
`ifdef VGA_PATTERN_EXT_EN
        MODE_EXT:    pix_d = ext_rgb;
`endif
        default:     pix_d = RGB_BLACK;
      endcase
    end
  end

`ifdef VGA_PATTERN_EXT_EN
  assign ext_req = active && (mode_q == MODE_EXT);
`endif

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk    (vga_clk),
    .rst_n  (vga_rst_n),
    .key_i  (key3),
    .press_o(press)
  );

  // A press coinciding with the frame-start edge lands in pending only; mode takes the old value.
  always_ff @(posedge vga_clk) begin
    if (!vga_rst_n) begin
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      rgb_q     <= '0;
      mode_q    <= '0;
      pending_q <= '0;
    end else begin
      if (press) pending_q <= (pending_q == MODE_LAST) ? 4'd0 : pending_q + 4'd1;
      if (run_q) begin
        hs_q  <= (hpos < 16'(H_SYNC)) ? HS_POL : ~HS_POL;
        vs_q  <= (vpos < 16'(V_SYNC)) ? VS_POL : ~VS_POL;
        de_q  <= active;
        fs_q  <= origin;
        rgb_q <= pix_d;
        if (origin) mode_q <= pending_q;
      end
    end
  end

  assign vga.vga_hs      = hs_q;
  assign vga.vga_vs      = vs_q;
  assign vga.vga_de      = de_q;
  assign vga.vga_r       = rgb_q[15:11];
  assign vga.vga_g       = rgb_q[10:5];
  assign vga.vga_b       = rgb_q[4:0];
  assign vga.frame_start = fs_q;
  assign vga.mode        = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a 16x4 raster (24x8 total) with a 4-cycle debounce.
// A frame-position model derived from the pattern rules predicts every output each cycle.
module tb_vga_pattern_gen;
  import vga_pattern_pkg::*;

  localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
  localparam int DB = 4;
  localparam int HT = HSY + HB + HA + HF;
  localparam int VT = VSY + VB + VA + VF;
  localparam int FRAME = HT * VT;
  localparam int P0 = (VSY + VB) * HT + HSY + HB;
`ifdef VGA_PATTERN_EXT_EN
  localparam int NMODES = 11;
`else
  localparam int NMODES = 10;
`endif
  localparam logic [15:0] EXT_VAL = 16'hA5C3;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic vga_clk = 1'b0;
  logic vga_rst_n = 1'b0;
  logic key3 = 1'b0;
  vga_pattern_gen_if vif ();
`ifdef VGA_PATTERN_EXT_EN
  logic [15:0] ext_rgb = EXT_VAL;
  logic        ext_req;
`endif

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .vga_clk  (vga_clk),
    .vga_rst_n(vga_rst_n),
    .key3     (key3),
    .vga      (vif)
`ifdef VGA_PATTERN_EXT_EN
    ,
    .ext_rgb  (ext_rgb),
    .ext_req  (ext_req)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  int tests = 0, fails = 0;
  wire [15:0] dut_rgb = {vif.vga_r, vif.vga_g, vif.vga_b};
  wire [23:0] got_v = {vif.vga_hs, vif.vga_vs, vif.vga_de, vif.frame_start, vif.mode, dut_rgb};

  // Model state: position of the visible outputs inside the frame, and the key/mode story.
  int cyc = 0, rel = 0, cur_p = -1, pending_m = 0, mode_m = 0, run = 0, kstart = 0;
  bit started = 0;
  int evq[$];
  logic exp_hs = 1'b1, exp_vs = 1'b1, exp_de = 1'b0, exp_fs = 1'b0;
  logic [15:0] exp_rgb = '0;
  logic [3:0]  exp_mode = '0;
  wire [23:0] exp_v = {exp_hs, exp_vs, exp_de, exp_fs, exp_mode, exp_rgb};

  function automatic logic [15:0] ref_pixel(int m, int x, int y);
    int r, g;
    case (m)
      0: return 16'hFFFF;
      1: return 16'hF800;
      2: return 16'h07E0;
      3: return 16'h001F;
      4: return (((x >> 4) ^ (y >> 4)) & 1) ? 16'h0000 : 16'hFFFF;
      5: return (((x >> 6) ^ (y >> 6)) & 1) ? 16'h0000 : 16'hFFFF;
      6: begin r = (x >> 2) & 31; g = (x >> 1) & 63; return 16'((r << 11) | (g << 5) | r); end
      7: begin r = (y >> 2) & 31; g = (y >> 1) & 63; return 16'((r << 11) | (g << 5) | r); end
      8: return (x / (HA / 8) >= 8) ? 16'h0000 : BARS[x / (HA / 8)];
      9: return (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? 16'hFFFF : 16'h0000;
      default: return EXT_VAL;
    endcase
  endfunction

  always @(posedge vga_clk) begin
    int h, v;
    cyc++;
    if (!vga_rst_n) begin
      started = 0; cur_p = -1; pending_m = 0; mode_m = 0; run = 0; evq.delete();
      exp_hs = 1'b1; exp_vs = 1'b1; exp_de = 1'b0; exp_fs = 1'b0; exp_rgb = '0; exp_mode = '0;
    end else begin
      if (!started) begin
        started = 1; rel = cyc;
      end else begin
        cur_p = (cyc - rel - 1) % FRAME;
        h = cur_p % HT; v = cur_p / HT;
        if (cur_p == 0) mode_m = pending_m;
        exp_hs = !(h < HSY); exp_vs = !(v < VSY);
        exp_de = (h >= HSY + HB) && (h < HSY + HB + HA) && (v >= VSY + VB) && (v < VSY + VB + VA);
        exp_rgb = exp_de ? ref_pixel(mode_m, h - HSY - HB, v - VSY - VB) : 16'h0000;
        exp_fs = (cur_p == 0);
        exp_mode = 4'(mode_m);
      end
      for (int i = evq.size() - 1; i >= 0; i--)
        if (evq[i] == cyc) begin pending_m = (pending_m + 1) % NMODES; evq.delete(i); end
      // A press held DB-1 sampled cycles is accepted; pending advances DB+1 edges after the first sample.
      if (key3) begin
        if (run == 0) kstart = cyc;
        run++;
        if (run == DB - 1) evq.push_back(kstart + DB + 1);
      end else begin
        run = 0;
      end
    end
  end

  task automatic wait_pos(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge vga_clk);
      if (cur_p == target) begin ok = 1; break; end
    end
  endtask

  task automatic press(input int len, input int gap);
    key3 = 1'b1;
    repeat (len) @(negedge vga_clk);
    key3 = 1'b0;
    repeat (gap) @(negedge vga_clk);
  endtask

  task automatic test_reset();
    vga_rst_n = 1'b0; key3 = 1'b0;
    repeat (5) @(negedge vga_clk);
    tests++; if (vif.vga_hs !== 1'b1) begin fails++; $display("FAIL reset_hs got=%b want=1", vif.vga_hs); end
    tests++; if (vif.vga_vs !== 1'b1) begin fails++; $display("FAIL reset_vs got=%b want=1", vif.vga_vs); end
    tests++; if (vif.vga_de !== 1'b0) begin fails++; $display("FAIL reset_de got=%b want=0", vif.vga_de); end
    tests++; if (dut_rgb !== 16'h0) begin fails++; $display("FAIL reset_rgb got=%h want=0000", dut_rgb); end
    tests++; if (vif.mode !== 4'd0) begin fails++; $display("FAIL reset_mode got=%0d want=0", vif.mode); end
    tests++; if (vif.frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs got=%b want=0", vif.frame_start); end
    vga_rst_n = 1'b1;
    @(negedge vga_clk);
    tests++; if (vif.frame_start !== 1'b0) begin fails++; $display("FAIL release_edge1_fs got=%b want=0", vif.frame_start); end
    @(negedge vga_clk);
    tests++; if ({vif.frame_start, vif.vga_hs, vif.vga_vs} !== 3'b100)
      begin fails++; $display("FAIL release_edge2 fs/hs/vs got=%b want=100", {vif.frame_start, vif.vga_hs, vif.vga_vs}); end
    $display("[TB] reset: done");
  endtask

  task automatic test_timing();
    int hs_low = 0, vs_low = 0, de_hi = 0, fs_n = 0, fs_first = -1, fs_last = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge vga_clk);
      tests++; if (got_v !== exp_v) begin fails++; $display("FAIL timing_cycle p=%0d got=%h want=%h", cur_p, got_v, exp_v); end
      hs_low += !vif.vga_hs; vs_low += !vif.vga_vs; de_hi += vif.vga_de;
      if (vif.frame_start) begin fs_n++; if (fs_first < 0) fs_first = i; fs_last = i; end
    end
    tests++; if (hs_low != 2 * HSY * VT) begin fails++; $display("FAIL hs_low_count got=%0d want=%0d", hs_low, 2 * HSY * VT); end
    tests++; if (vs_low != 2 * VSY * HT) begin fails++; $display("FAIL vs_low_count got=%0d want=%0d", vs_low, 2 * VSY * HT); end
    tests++; if (de_hi != 2 * HA * VA) begin fails++; $display("FAIL de_count got=%0d want=%0d", de_hi, 2 * HA * VA); end
    tests++; if (fs_n != 2 || fs_last - fs_first != FRAME)
      begin fails++; $display("FAIL fs_period got=%0d pulses span %0d want=2 span %0d", fs_n, fs_last - fs_first, FRAME); end
    $display("[TB] timing: hs_low=%0d vs_low=%0d de=%0d", hs_low, vs_low, de_hi);
  endtask

  task automatic test_press();
    bit ok;
    wait_pos(40, ok); press(10, 4);
    wait_pos(FRAME - 1, ok);
    tests++; if (!ok || vif.mode !== 4'd0) begin fails++; $display("FAIL press_before_frame mode=%0d want=0 ok=%b", vif.mode, ok); end
    @(negedge vga_clk);
    tests++; if ({vif.frame_start, vif.mode} !== {1'b1, 4'd1})
      begin fails++; $display("FAIL press_at_frame fs=%b mode=%0d want fs=1 mode=1", vif.frame_start, vif.mode); end
    wait_pos(P0, ok);
    tests++; if (!ok || {vif.vga_de, dut_rgb} !== {1'b1, 16'hF800})
      begin fails++; $display("FAIL press_red_pixel de=%b rgb=%h want de=1 rgb=F800", vif.vga_de, dut_rgb); end
    $display("[TB] press: mode=%0d", vif.mode);
  endtask

  task automatic test_short_accum();
    bit ok;
    wait_pos(20, ok); press(2, 4);
    wait_pos(1, ok);
    tests++; if (!ok || vif.mode !== 4'd1) begin fails++; $display("FAIL short_press mode=%0d want=1", vif.mode); end
    wait_pos(10, ok);
    repeat (3) press(8, 4);
    wait_pos(1, ok);
    tests++; if (!ok || vif.mode !== 4'd4) begin fails++; $display("FAIL accumulate mode=%0d want=4", vif.mode); end
    $display("[TB] short/accum: mode=%0d", vif.mode);
  endtask

  task automatic test_colour_bars();
    bit ok;
    wait_pos(10, ok);
    repeat (4) press(8, 4);
    wait_pos(1, ok); wait_pos(P0, ok);
    tests++; if (!ok || vif.mode !== 4'd8) begin fails++; $display("FAIL bars_mode mode=%0d want=8", vif.mode); end
    for (int i = 0; i < HA; i++) begin
      tests++; if (dut_rgb !== BARS[i / 2]) begin fails++; $display("FAIL bar_pixel x=%0d got=%h want=%h", i, dut_rgb, BARS[i / 2]); end
      @(negedge vga_clk);
    end
    tests++; if ({vif.vga_de, dut_rgb} !== 17'h0) begin fails++; $display("FAIL bar_after_line de=%b rgb=%h want 0/0000", vif.vga_de, dut_rgb); end
    $display("[TB] colour bars: checked %0d pixels", HA);
  endtask

  task automatic test_same_cycle();
    bit ok;
    // Starting DB+2 cycles before the frame edge makes pending advance on that very edge.
    wait_pos(FRAME - (DB + 2), ok);
    press(10, 0);
    tests++; if (!ok || vif.mode !== 4'd8) begin fails++; $display("FAIL same_cycle_first mode=%0d want=8", vif.mode); end
    wait_pos(1, ok);
    tests++; if (!ok || vif.mode !== 4'd9) begin fails++; $display("FAIL same_cycle_next mode=%0d want=9", vif.mode); end
    $display("[TB] same-cycle press: mode=%0d", vif.mode);
  endtask

  task automatic test_wrap();
    bit ok;
    wait_pos(10, ok);
    repeat (10) press(8, 3);
    wait_pos(1, ok);
    tests++; if (!ok || vif.mode !== 4'((9 + 10) % NMODES)) begin fails++; $display("FAIL wrap_ten mode=%0d want=%0d", vif.mode, (9 + 10) % NMODES); end
    wait_pos(10, ok); press(8, 3);
    wait_pos(1, ok);
    tests++; if (!ok || vif.mode !== 4'((9 + 11) % NMODES)) begin fails++; $display("FAIL wrap_eleven mode=%0d want=%0d", vif.mode, (9 + 11) % NMODES); end
    $display("[TB] wrap: mode=%0d", vif.mode);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    n = (5 - mode_m + NMODES) % NMODES;
    wait_pos(10, ok);
    repeat (n) press(8, 3);
    wait_pos(1, ok);
    tests++; if (!ok || vif.mode !== 4'd5) begin fails++; $display("FAIL midreset_setup mode=%0d want=5", vif.mode); end
    wait_pos(3 * HT + 5, ok);
    vga_rst_n = 1'b0;
    @(negedge vga_clk);
    tests++; if ({vif.mode, vif.vga_hs, vif.vga_vs, vif.vga_de, vif.frame_start} !== {4'd0, 4'b1100})
      begin fails++; $display("FAIL midreset_values mode=%0d hs/vs/de/fs=%b want 0/1100", vif.mode,
                              {vif.vga_hs, vif.vga_vs, vif.vga_de, vif.frame_start}); end
    vga_rst_n = 1'b1;
    @(negedge vga_clk);
    tests++; if (vif.frame_start !== 1'b0) begin fails++; $display("FAIL midreset_edge1_fs got=%b want=0", vif.frame_start); end
    @(negedge vga_clk);
    tests++; if ({vif.frame_start, vif.mode} !== {1'b1, 4'd0})
      begin fails++; $display("FAIL midreset_edge2 fs=%b mode=%0d want fs=1 mode=0", vif.frame_start, vif.mode); end
    $display("[TB] mid-frame reset: done");
  endtask

  task automatic test_random();
    int hold = 0, gap = 0, presses = 0;
    for (int i = 0; i < 12 * FRAME; i++) begin
      @(negedge vga_clk);
      tests++; if (got_v !== exp_v) begin fails++; $display("FAIL random_cycle p=%0d got=%h want=%h", cur_p, got_v, exp_v); end
      if (hold > 0) begin key3 = 1'b1; hold--; end
      else if (gap > 0) begin key3 = 1'b0; gap--; end
      else begin
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(DB + 1, DB + 8);
        gap = $urandom_range(2, 60);
        presses++;
      end
    end
    key3 = 1'b0;
    $display("[TB] random: %0d key pulses, final mode=%0d", presses, vif.mode);
  endtask

  initial begin
    test_reset();
    test_timing();
    test_press();
    test_short_accum();
    test_colour_bars();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
